// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit holding HI/LO, with MFHI/MFLO write-back and pipeline stall.
// Optional MTHI/MTLO write path is enabled by defining MDU_MTHI_MTLO_EN.
//
// state | meaning
// IDLE  | waiting for start; MF/MT requests served
// SETUP | take operand magnitudes, record signs, clear accumulator/counter
// RUN   | one radix-2 shift-add / restoring shift-subtract step per cycle
// FIXUP | sign correction and special cases, write HI/LO
module mdu_hilo #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            mf_req,
  input  logic            mf_sel,
  input  logic [4:0]      mf_dst,
`ifdef MDU_MTHI_MTLO_EN
  input  logic            mt_req,
  input  logic            mt_sel,
`endif
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_reg,
  output logic            wb_we
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, FIXUP} state_e;

  state_e          state_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, acc_q, wrk_q, dvs_q, hi_q, lo_q, wb_data_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_a_q, neg_b_q, busy_q, done_q, wb_we_q;
  logic [4:0]      wb_reg_q;

  logic            is_div, is_signed;
  logic [XLEN:0]   mul_sum, div_trial, div_diff;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] abs_a, abs_b, quot_fix, rem_fix, hi_d, lo_d;
  logic            mt_any;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

`ifdef MDU_MTHI_MTLO_EN
  assign mt_any = mt_req;
`else
  assign mt_any = 1'b0;
`endif

  always_comb begin
    abs_a     = (is_signed && a_q[XLEN-1]) ? -a_q : a_q;
    abs_b     = (is_signed && b_q[XLEN-1]) ? -b_q : b_q;
    mul_sum   = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, dvs_q} : '0);
    div_trial = {acc_q, wrk_q[XLEN-1]};
    div_diff  = div_trial - {1'b0, dvs_q};
    prod      = {acc_q, wrk_q};
    prod_fix  = (neg_a_q ^ neg_b_q) ? -prod : prod;
    quot_fix  = (neg_a_q ^ neg_b_q) ? -wrk_q : wrk_q;
    rem_fix   = neg_a_q ? -acc_q : acc_q;
    hi_d      = rem_fix;
    lo_d      = quot_fix;
    if (!is_div) begin
      {hi_d, lo_d} = prod_fix;
    end else if (b_q == '0) begin
      hi_d = a_q;
      lo_d = '1;
    end else if (is_signed && a_q == {1'b1, {(XLEN-1){1'b0}}} && b_q == '1) begin
      hi_d = '0;
      lo_d = {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      wrk_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wb_data_q <= '0;
      wb_reg_q  <= 5'd0;
      wb_we_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      wb_we_q <= 1'b0;
      if (mf_req && !busy_q) begin
        wb_data_q <= mf_sel ? hi_q : lo_q;
        wb_reg_q  <= mf_dst;
        wb_we_q   <= (mf_dst != 5'd0);
      end
`ifdef MDU_MTHI_MTLO_EN
      // An accompanying start would overwrite HI/LO anyway, so the MT write is dropped.
      if (mt_req && !busy_q && !start) begin
        if (mt_sel) hi_q <= src_a;
        else        lo_q <= src_a;
      end
`endif
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            a_q     <= src_a;
            b_q     <= src_b;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          neg_a_q <= is_signed & a_q[XLEN-1];
          neg_b_q <= is_signed & b_q[XLEN-1];
          wrk_q   <= abs_a;
          dvs_q   <= abs_b;
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          if (!is_div) begin
            acc_q <= mul_sum[XLEN:1];
            wrk_q <= {mul_sum[0], wrk_q[XLEN-1:1]};
          end else if (!div_diff[XLEN]) begin
            acc_q <= div_diff[XLEN-1:0];
            wrk_q <= {wrk_q[XLEN-2:0], 1'b1};
          end else begin
            acc_q <= div_trial[XLEN-1:0];
            wrk_q <= {wrk_q[XLEN-2:0], 1'b0};
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN-1)) state_q <= FIXUP;
        end
        FIXUP: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall   = busy_q & (start | mf_req | mt_any);
  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign wb_data = wb_data_q;
  assign wb_reg  = wb_reg_q;
  assign wb_we   = wb_we_q;

endmodule
